serial_adder: RTL

- Bit-serial, LSB-first adder; the addition counterpart of the half/full subtractor blocks.
- Latches two WIDTH-bit operands on a start pulse and resolves one bit per clock through a single full-adder cell and a carry flip-flop.
- Presents sum and carry-out with a one-cycle done pulse.
- Intended as a small-area arithmetic unit in lab datapaths, and as a stimulus/response target for the existing combinational arithmetic benches.

---
 rtl/serial_adder_pkg.sv | 26 ++
 rtl/full_adder_bit.sv | 19 +
 rtl/serial_adder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder: FSM state encoding and a
//   ceiling-log2 helper used to size the bit counter.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Minimum 1 bit so a counter is always declarable.
   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      if (r == 0) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/full_adder_bit.sv
// full_adder_bit
//   Combinational one-bit full adder, shared with the subtractor family.
//   Ports:
//     i_a, i_b  - operand bits
//     i_cin     - carry in
//     o_s       - sum bit
//     o_cout    - carry out (majority of the three inputs)
module full_adder_bit (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_s,
   output logic o_cout
);

   assign o_s    = i_a ^ i_b ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial, LSB-first adder. Operands are latched on an accepted start
//   and resolved one bit per clock through a single full_adder_bit and a
//   carry flip-flop. Result and carry-out are registered and presented with
//   a one-cycle done pulse.
//   Optional macro SERIAL_ADDER_SUB_EN adds port sub: when set at start the
//   block computes a-b (a + ~b + 1) and cout reports borrow (1 when a<b).
//   Ports:
//     clk, rst_n  - clock, asynchronous active-low reset
//     start       - request, sampled only when busy=0
//     a, b        - operands, captured at the accepted start
//     sub         - subtract select (only with SERIAL_ADDER_SUB_EN)
//     busy        - operation in progress
//     done        - one-cycle result-valid pulse
//     sum, cout   - registered result and carry/borrow out
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start
//   ST_SHIFT | one operand bit resolved per clock, WIDTH clocks in total
//   ST_DONE  | done pulse; a start here is accepted like in ST_IDLE
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int            CW   = clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_sum;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic             r_cout;
   logic             r_sub;
   logic             w_accept;
   logic             w_last;
   logic             w_s;
   logic             w_c;
   logic             w_sub;

`ifdef SERIAL_ADDER_SUB_EN
   assign w_sub = sub;
`else
   assign w_sub = 1'b0;
`endif

   assign w_last = (r_cnt == LAST);

   full_adder_bit u_fa (
      .i_a    (r_a_sr[0]),
      .i_b    (r_b_sr[0]),
      .i_cin  (r_carry),
      .o_s    (w_s),
      .o_cout (w_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (w_last) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_SHIFT;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sr  <= '0;
         r_b_sr  <= '0;
         r_acc   <= '0;
         r_sum   <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_sub   <= 1'b0;
      end else if (w_accept) begin
         // Subtraction reuses the adder: invert b and inject carry-in 1.
         r_a_sr  <= a;
         r_b_sr  <= w_sub ? ~b : b;
         r_carry <= w_sub;
         r_sub   <= w_sub;
         r_cnt   <= '0;
         r_acc   <= '0;
      end else if (r_state == ST_SHIFT) begin
         r_a_sr  <= r_a_sr >> 1;
         r_b_sr  <= r_b_sr >> 1;
         r_carry <= w_c;
         r_cnt   <= r_cnt + CW'(1);
         r_acc   <= {w_s, r_acc[WIDTH-1:1]};
         if (w_last) begin
            r_sum  <= {w_s, r_acc[WIDTH-1:1]};
            // Borrow is the complement of the final carry when subtracting.
            r_cout <= w_c ^ r_sub;
         end
      end
   end

   assign busy = (r_state == ST_SHIFT);
   assign done = (r_state == ST_DONE);
   assign sum  = r_sum;
   assign cout = r_cout;

endmodule
